// File: rtl/mealy_pkg.sv
// Shared state encoding and next-state function for the Mealy sequencer,
// its output decoder and any reference model.
package mealy_pkg;

    typedef enum logic [1:0] {
        A = 2'b00,
        B = 2'b01,
        C = 2'b10,
        D = 2'b11
    } mstate_t;

    // D is absorbing: every input keeps the machine there.
    function automatic mstate_t next_state(input mstate_t s, input logic b);
        mstate_t n;
        case (s)
            A:       n = b ? C : B;
            B:       n = b ? A : D;
            C:       n = b ? D : B;
            default: n = D;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bit_fifo.sv
// Single-bit FIFO with pointer wrap and a level counter that separates full from empty.
// Push and pop may share a cycle; the caller gates push with !full and pop with !empty.
module bit_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    // Head is meaningless when empty; hold it at 0 so the decoder sees a clean value.
    assign dout  = empty ? 1'b0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mealy_seq_ctrl.sv
// Sequencing stage: buffers serial input bits and applies one per cycle to the
// 4-state Mealy next-state function whenever downstream asserts adv.
module mealy_seq_ctrl
    import mealy_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_bit,
    output logic                    in_ready,
    input  logic                    adv,
    input  logic                    restart,
    output logic [1:0]              state,
    output logic                    cur_in,
    output logic                    cur_valid,
    output logic [CW-1:0]           step_count,
    output logic                    absorbed,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    // Handshake: a bit moves on in_valid && in_ready; a transition happens on cur_valid.
    // Neither ready nor cur_valid looks at in_valid, and a full FIFO never bypasses.
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    mstate_t state_q;
    mstate_t state_d;
    logic [CW-1:0] count_q;
    logic    absorbed_q;

    assign in_ready  = !fifo_full && !restart && rst_n;
    assign cur_valid = !fifo_empty && adv && !restart && rst_n;
    assign push      = in_valid && in_ready;

    bit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in_bit),
        .pop   (cur_valid),
        .flush (restart),
        .dout  (cur_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign state_d = next_state(state_q, cur_in);

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            state_q    <= A;
            count_q    <= '0;
            absorbed_q <= 1'b0;
        end else if (cur_valid) begin
            state_q    <= state_d;
            absorbed_q <= (state_d == D);
            if (count_q != {CW{1'b1}}) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign state      = state_q;
    assign step_count = count_q;
    assign absorbed   = absorbed_q;

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Directed bench for mealy_seq_ctrl: a DEPTH=4/CW=8 instance for the main scenarios
// and a CW=4 instance on the same inputs for counter saturation.
module tb_mealy_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       adv = 1'b0;
  logic       restart = 1'b0;

  logic       in_ready, cur_in, cur_valid, absorbed;
  logic [1:0] state;
  logic [7:0] step_count;
  logic [2:0] fifo_level;

  logic       in_ready2, cur_in2, cur_valid2, absorbed2;
  logic [1:0] state2;
  logic [3:0] step_count2;
  logic [2:0] fifo_level2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mealy_seq_ctrl #(.DEPTH(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .adv(adv), .restart(restart), .state(state),
    .cur_in(cur_in), .cur_valid(cur_valid), .step_count(step_count),
    .absorbed(absorbed), .fifo_level(fifo_level)
  );

  mealy_seq_ctrl #(.DEPTH(4), .CW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready2), .adv(adv), .restart(restart), .state(state2),
    .cur_in(cur_in2), .cur_valid(cur_valid2), .step_count(step_count2),
    .absorbed(absorbed2), .fifo_level(fifo_level2)
  );

  // Independent transition table for the bench model.
  function automatic logic [1:0] model_next(input logic [1:0] s, input logic b);
    logic [1:0] tbl [0:7];
    tbl[0] = 2'b01; tbl[1] = 2'b10;
    tbl[2] = 2'b11; tbl[3] = 2'b00;
    tbl[4] = 2'b01; tbl[5] = 2'b11;
    tbl[6] = 2'b11; tbl[7] = 2'b11;
    return tbl[{s, b}];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    in_valid = 1'b0;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_bit = 1'b1; adv = 1'b1;
    settle();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    checks++;
    if (cur_valid !== 1'b0) begin errors++; $display("FAIL rst_cur_valid got %0b want 0", cur_valid); end
    tick();
    tick();
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++;
    if (step_count !== 8'd0) begin errors++; $display("FAIL rst_step got %0d want 0", step_count); end
    checks++;
    if (absorbed !== 1'b0) begin errors++; $display("FAIL rst_absorbed got %0b want 0", absorbed); end
    rst_n = 1'b1; in_valid = 1'b0;
    settle();
    checks++;
    if (cur_valid !== 1'b0) begin errors++; $display("FAIL rst_release_cur_valid got %0b want 0", cur_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b want 1", in_ready); end
    tick();
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_release_level got %0d want 0", fifo_level); end
    adv = 1'b0;
  endtask

  task automatic test_bits_00();
    adv = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
    settle();
    checks++;
    if (cur_valid !== 1'b0) begin errors++; $display("FAIL b00_no_bypass got %0b want 0", cur_valid); end
    tick();
    settle();
    checks++;
    if (cur_valid !== 1'b1 || state !== 2'b00 || cur_in !== 1'b0) begin
      errors++; $display("FAIL b00_first got v=%0b s=%0d in=%0b want v=1 s=0 in=0", cur_valid, state, cur_in);
    end
    tick();
    in_valid = 1'b0;
    settle();
    checks++;
    if (cur_valid !== 1'b1 || state !== 2'b01 || cur_in !== 1'b0 || fifo_level !== 3'd1) begin
      errors++; $display("FAIL b00_second got v=%0b s=%0d in=%0b lvl=%0d want v=1 s=1 in=0 lvl=1", cur_valid, state, cur_in, fifo_level);
    end
    tick();
    checks++;
    if (state !== 2'b11 || absorbed !== 1'b1 || step_count !== 8'd2) begin
      errors++; $display("FAIL b00_final got s=%0d abs=%0b cnt=%0d want s=3 abs=1 cnt=2", state, absorbed, step_count);
    end
    checks++;
    if (cur_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL b00_empty got v=%0b lvl=%0d want v=0 lvl=0", cur_valid, fifo_level);
    end
    do_restart();
  endtask

  task automatic test_bits_101();
    logic [2:0] bits;
    logic [1:0] exp_s [0:3];
    bits = 3'b101;
    exp_s[0] = 2'b00; exp_s[1] = 2'b10; exp_s[2] = 2'b01; exp_s[3] = 2'b00;
    adv = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 3);
      in_bit = (c < 3) ? bits[2 - c] : 1'b0;
      tick();
      checks++;
      if (state !== exp_s[c]) begin errors++; $display("FAIL b101_state_%0d got %0d want %0d", c, state, exp_s[c]); end
    end
    checks++;
    if (state !== 2'b00 || step_count !== 8'd3 || absorbed !== 1'b0) begin
      errors++; $display("FAIL b101_final got s=%0d cnt=%0d abs=%0b want s=0 cnt=3 abs=0", state, step_count, absorbed);
    end
    in_valid = 1'b0;
    do_restart();
  endtask

  task automatic test_full_and_share();
    logic [4:0] fill;
    logic [5:0] offer, exp_in, exp_rdy;
    fill    = 5'b10011;
    offer   = 6'b001101;
    exp_in  = 6'b100101;
    exp_rdy = 6'b011111;
    adv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = fill[4 - i];
      settle();
      checks++;
      if (in_ready !== (i < 4)) begin errors++; $display("FAIL full_ready_%0d got %0b want %0b", i, in_ready, (i < 4)); end
      tick();
    end
    checks++;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", fifo_level); end
    adv = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_bit = offer[5 - k];
      settle();
      checks++;
      if (cur_valid !== 1'b1 || cur_in !== exp_in[5 - k] || in_ready !== exp_rdy[5 - k]) begin
        errors++; $display("FAIL share_%0d got v=%0b in=%0b rdy=%0b want v=1 in=%0b rdy=%0b",
                           k, cur_valid, cur_in, in_ready, exp_in[5 - k], exp_rdy[5 - k]);
      end
      tick();
    end
    checks++;
    if (fifo_level !== 3'd3) begin errors++; $display("FAIL share_level got %0d want 3", fifo_level); end
    in_valid = 1'b0;
    do_restart();
  endtask

  task automatic test_restart();
    adv = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    adv = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_bit = (i != 2);
      tick();
    end
    checks++;
    if (state !== 2'b10 || fifo_level !== 3'd3 || step_count !== 8'd1) begin
      errors++; $display("FAIL rs_setup got s=%0d lvl=%0d cnt=%0d want s=2 lvl=3 cnt=1", state, fifo_level, step_count);
    end
    restart = 1'b1; in_valid = 1'b1; in_bit = 1'b1; adv = 1'b1;
    settle();
    checks++;
    if (in_ready !== 1'b0 || cur_valid !== 1'b0) begin
      errors++; $display("FAIL rs_comb got rdy=%0b v=%0b want rdy=0 v=0", in_ready, cur_valid);
    end
    tick();
    restart = 1'b0; in_valid = 1'b0;
    settle();
    checks++;
    if (state !== 2'b00 || fifo_level !== 3'd0 || step_count !== 8'd0 || absorbed !== 1'b0 || cur_valid !== 1'b0) begin
      errors++; $display("FAIL rs_after got s=%0d lvl=%0d cnt=%0d abs=%0b v=%0b want all 0",
                         state, fifo_level, step_count, absorbed, cur_valid);
    end
    adv = 1'b0;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_s;
    logic [3:0] exp_cnt;
    logic       b;
    logic [19:0] bits;
    rst_n = 1'b0; in_valid = 1'b0; adv = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) bits[i] = (i >= 18) ? 1'b0 : ((i % 3) != 1);
    exp_s = 2'b00;
    exp_cnt = 4'd0;
    adv = 1'b1;
    for (int c = 0; c < 22; c++) begin
      in_valid = (c < 20);
      in_bit = (c < 20) ? bits[c] : 1'b0;
      tick();
      if (c >= 1 && c <= 20) begin
        b = bits[c - 1];
        exp_s = model_next(exp_s, b);
        if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
      end
      checks++;
      if (state2 !== exp_s || absorbed2 !== (exp_s == 2'b11) || step_count2 !== exp_cnt) begin
        errors++; $display("FAIL sat_cycle_%0d got s=%0d abs=%0b cnt=%0d want s=%0d abs=%0b cnt=%0d",
                           c, state2, absorbed2, step_count2, exp_s, (exp_s == 2'b11), exp_cnt);
      end
    end
    checks++;
    if (step_count2 !== 4'd15 || state2 !== 2'b11) begin
      errors++; $display("FAIL sat_final got cnt=%0d s=%0d want cnt=15 s=3", step_count2, state2);
    end
    checks++;
    if (step_count !== 8'd20) begin errors++; $display("FAIL sat_wide_cnt got %0d want 20", step_count); end
    in_valid = 1'b0; adv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bits_00();
    test_bits_101();
    test_full_and_share();
    test_restart();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
